// File: rtl/reset_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reset_seq_pkg
// Description : Shared definitions for the board reset sequencer. Holds the
//               sequencer state encoding, the reset-cause codes reported to
//               firmware, and a small constant helper used for width sizing.
// Revision    : 1.0 - initial release
// ============================================================================
package reset_seq_pkg;

  // Sequencer states, explicitly 2 bits wide.
  //   HOLD_POR : power-on / pushbutton reset, waiting for the rst_n synchronizer
  //   SEQ      : releasing domains one by one
  //   RUN      : all domains released
  //   HOLD     : all domains held after an external or software reset
  typedef enum logic [1:0] {
    HOLD_POR = 2'd0,
    SEQ      = 2'd1,
    RUN      = 2'd2,
    HOLD     = 2'd3
  } seq_state_e;

  // Cause of the most recent reset event, as seen by firmware.
  localparam logic [1:0] CAUSE_POR = 2'd0;
  localparam logic [1:0] CAUSE_EXT = 2'd1;
  localparam logic [1:0] CAUSE_SW  = 2'd2;

  // Larger of two unsigned constants; used to size the shared delay counter.
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage : reset_seq_pkg
`default_nettype wire

// File: rtl/bit_synchronizer.sv
`default_nettype none
// ============================================================================
// Module      : bit_synchronizer
// Description : Multi-flop single-bit synchronizer with an asynchronous clear
//               to a selectable value.
// Ports       : clock  - destination clock
//               rst_n  - asynchronous active-low clear (all stages -> RESET_VAL)
//               d      - asynchronous input bit
//               q      - synchronized output (last stage)
// Revision    : 1.0 - initial release
// ============================================================================
module bit_synchronizer
  import reset_seq_pkg::*;
#(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  if (STAGES < 2) begin : g_bad_stages
    $error("bit_synchronizer: STAGES must be at least 2");
  end

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Stage 0 captures the raw input; each later stage copies its predecessor.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule : bit_synchronizer
`default_nettype wire

// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : reset_sequencer
// Description : Board-level reset controller. Releases NUM_DOMAINS active-low
//               reset nets in order (domain 0 first), STEP_DELAY_CYCLES apart,
//               after power-on, external or software reset. External and
//               software resets hold every domain for at least HOLD_CYCLES
//               before the release sequence restarts. The cause of the last
//               reset is kept for firmware readback.
// Ports       : clock        - system clock
//               rst_n        - async active-low power-on/pushbutton reset
//               ext_rst_in_n - async active-low external reset request (level)
//               sw_rst_req   - synchronous software reset request
//               rst_out_n    - per-domain active-low resets, bit k = domain k
//               seq_done     - all domains released
//               busy         - at least one domain still in reset
//               rst_cause    - 0 = POR, 1 = external, 2 = software
// Revision    : 1.0 - initial release
// ============================================================================
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned NUM_DOMAINS       = 4,
  parameter int unsigned STEP_DELAY_CYCLES = 1000,
  parameter int unsigned HOLD_CYCLES       = 16,
  parameter int unsigned SYNC_STAGES       = 2
) (
  input  logic                   clock,
  input  logic                   rst_n,
  input  logic                   ext_rst_in_n,
  input  logic                   sw_rst_req,
  output logic [NUM_DOMAINS-1:0] rst_out_n,
  output logic                   seq_done,
  output logic                   busy,
  output logic [1:0]             rst_cause
);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter range check
  // --------------------------------------------------------------------------
  if ((NUM_DOMAINS < 1) || (NUM_DOMAINS > 8) || (STEP_DELAY_CYCLES < 1) ||
      (HOLD_CYCLES < 1) || (SYNC_STAGES < 2)) begin : g_bad_params
    $error("reset_sequencer: parameter out of range");
  end

  // --------------------------------------------------------------------------
  // Derived constants
  // --------------------------------------------------------------------------
  localparam int unsigned CNT_MAX = max_u(STEP_DELAY_CYCLES, HOLD_CYCLES);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned STEP_W  = $clog2(NUM_DOMAINS + 1);

  localparam logic [CNT_W-1:0]  STEP_LAST   = CNT_W'(STEP_DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0]  HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [STEP_W-1:0] LAST_DOMAIN = STEP_W'(NUM_DOMAINS - 1);

  // --------------------------------------------------------------------------
  // Synchronizers
  // --------------------------------------------------------------------------
  logic w_por_sync;   // goes high SYNC_STAGES edges after rst_n deasserts
  logic w_ext_sync;   // synchronized ext_rst_in_n, cleared to inactive

  bit_synchronizer #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b0)
  ) u_por_sync (
    .clock (clock),
    .rst_n (rst_n),
    .d     (1'b1),
    .q     (w_por_sync)
  );

  bit_synchronizer #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_ext_sync (
    .clock (clock),
    .rst_n (rst_n),
    .d     (ext_rst_in_n),
    .q     (w_ext_sync)
  );

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  seq_state_e             state_q,    state_d;
  logic [CNT_W-1:0]       count_q,    count_d;
  logic [STEP_W-1:0]      step_q,     step_d;
  logic [NUM_DOMAINS-1:0] rst_out_q,  rst_out_d;
  logic                   seq_done_q, seq_done_d;
  logic                   busy_q,     busy_d;
  logic [1:0]             cause_q,    cause_d;

  // --------------------------------------------------------------------------
  // Event decode
  // --------------------------------------------------------------------------
  logic              w_ext_evt;
  logic              w_sw_evt;
  logic              w_seq_clk;
  logic [CNT_W-1:0]  w_seq_count;
  logic [STEP_W-1:0] w_seq_step;
  logic              w_release;

  // External reset applies everywhere except during power-on hold; it also
  // takes precedence over a software request seen on the same edge.
  assign w_ext_evt = ~w_ext_sync & (state_q != HOLD_POR);
  assign w_sw_evt  = sw_rst_req & ((state_q == SEQ) | (state_q == RUN));

  // The edge on which HOLD_POR sees the synchronizer high already counts as
  // the first step clock of domain 0, so domain k releases exactly
  // SYNC_STAGES + (k+1)*STEP_DELAY_CYCLES edges after rst_n deasserts.
  // On that edge the step logic starts from count 0, step 0.
  assign w_seq_clk   = (state_q == SEQ) | ((state_q == HOLD_POR) & w_por_sync);
  assign w_seq_count = (state_q == SEQ) ? count_q : '0;
  assign w_seq_step  = (state_q == SEQ) ? step_q  : '0;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= HOLD_POR;
      count_q    <= '0;
      step_q     <= '0;
      rst_out_q  <= '0;
      seq_done_q <= 1'b0;
      busy_q     <= 1'b1;
      cause_q    <= CAUSE_POR;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      step_q     <= step_d;
      rst_out_q  <= rst_out_d;
      seq_done_q <= seq_done_d;
      busy_q     <= busy_d;
      cause_q    <= cause_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    step_d    = step_q;
    w_release = 1'b0;

    if (w_ext_evt || w_sw_evt) begin
      // Any reset event aborts the sequence. While the external request stays
      // low this branch reloads the hold counter every cycle.
      state_d = HOLD;
      count_d = '0;
      step_d  = '0;
    end else if (w_seq_clk) begin
      state_d = SEQ;
      if (w_seq_count == STEP_LAST) begin
        w_release = 1'b1;
        count_d   = '0;
        step_d    = w_seq_step + STEP_W'(1);
        if (w_seq_step == LAST_DOMAIN) begin
          state_d = RUN;
        end
      end else begin
        count_d = w_seq_count + CNT_W'(1);
        step_d  = w_seq_step;
      end
    end else if (state_q == HOLD) begin
      if (count_q == HOLD_LAST) begin
        state_d = SEQ;
        count_d = '0;
        step_d  = '0;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output logic (registered via the state register process)
  // --------------------------------------------------------------------------
  always_comb begin
    rst_out_d = rst_out_q;
    cause_d   = cause_q;

    if (w_ext_evt) begin
      rst_out_d = '0;
      cause_d   = CAUSE_EXT;
    end else if (w_sw_evt) begin
      rst_out_d = '0;
      cause_d   = CAUSE_SW;
    end else if (w_release) begin
      // Releases are cumulative: earlier domains stay released.
      for (int k = 0; k < int'(NUM_DOMAINS); k++) begin
        if (w_seq_step == STEP_W'(k)) begin
          rst_out_d[k] = 1'b1;
        end
      end
    end

    seq_done_d = (state_d == RUN);
    busy_d     = ~&rst_out_d;
  end

  assign rst_out_n = rst_out_q;
  assign seq_done  = seq_done_q;
  assign busy      = busy_q;
  assign rst_cause = cause_q;

endmodule : reset_sequencer
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_reset_sequencer
// Description : Self-checking bench for reset_sequencer. A per-edge reference
//               model derived from the release-time rules pushes expected
//               outputs into a scoreboard queue; a monitor on the falling edge
//               pops and compares. Directed scenarios are followed by a
//               randomized phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reset_sequencer;

  localparam int N    = 3;
  localparam int STEP = 4;
  localparam int HOLD = 3;
  localparam int SYNC = 2;

  logic         clock = 1'b0;
  logic         rst_n = 1'b0;
  logic         ext_rst_in_n = 1'b1;
  logic         sw_rst_req = 1'b0;
  logic [N-1:0] rst_out_n;
  logic         seq_done;
  logic         busy;
  logic [1:0]   rst_cause;

  reset_sequencer #(
    .NUM_DOMAINS       (N),
    .STEP_DELAY_CYCLES (STEP),
    .HOLD_CYCLES       (HOLD),
    .SYNC_STAGES       (SYNC)
  ) dut (
    .clock        (clock),
    .rst_n        (rst_n),
    .ext_rst_in_n (ext_rst_in_n),
    .sw_rst_req   (sw_rst_req),
    .rst_out_n    (rst_out_n),
    .seq_done     (seq_done),
    .busy         (busy),
    .rst_cause    (rst_cause)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [N-1:0] rst;
    logic         done;
    logic         bsy;
    logic [1:0]   cause;
  } exp_t;

  exp_t exp_q[$];
  int   edge_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state, expressed as edge numbers since rst_n released:
  //   m_edge  : current edge number (edge 1 = first edge with rst_n high)
  //   m_base  : edge at which the current release sequence starts counting
  //   m_armed : first edge at which a software request is honoured
  int         m_edge;
  int         m_base;
  int         m_armed;
  logic [1:0] m_cause;
  logic       ext_dl[$];   // ext samples delayed by the synchronizer depth

  task automatic model_edge();
    exp_t x;
    logic ext_seen;
    if (!rst_n) begin
      m_edge  = 0;
      m_base  = SYNC;
      m_armed = SYNC + 2;
      m_cause = 2'd0;
      ext_dl.delete();
      for (int i = 0; i < SYNC; i++) ext_dl.push_back(1'b1);
    end else begin
      m_edge++;
      ext_seen = ext_dl.pop_front();
      ext_dl.push_back(ext_rst_in_n);
      if ((m_edge >= SYNC + 2) && !ext_seen) begin
        m_cause = 2'd1;
        m_base  = m_edge + HOLD;
        m_armed = m_edge + HOLD + 1;
      end else if ((m_edge >= m_armed) && sw_rst_req) begin
        m_cause = 2'd2;
        m_base  = m_edge + HOLD;
        m_armed = m_edge + HOLD + 1;
      end
    end
    for (int k = 0; k < N; k++) begin
      x.rst[k] = rst_n && (m_edge >= m_base + (k + 1) * STEP);
    end
    x.done  = &x.rst;
    x.bsy   = ~&x.rst;
    x.cause = m_cause;
    exp_q.push_back(x);
    edge_q.push_back(m_edge);
  endtask

  // One clock of stimulus: inputs change just after the falling edge, the
  // model advances on the rising edge with the values the DUT sampled.
  task automatic drive(input logic sw, input logic ext, input logic rn);
    @(negedge clock);
    #1;
    sw_rst_req   = sw;
    ext_rst_in_n = ext;
    rst_n        = rn;
    @(posedge clock);
    model_edge();
  endtask

  // Assert rst_n between clock edges and confirm the outputs clear at once.
  task automatic async_reset();
    exp_t want;
    @(negedge clock);
    #1;
    sw_rst_req   = 1'b0;
    ext_rst_in_n = 1'b1;
    rst_n        = 1'b0;
    #1;
    want.rst   = '0;
    want.done  = 1'b0;
    want.bsy   = 1'b1;
    want.cause = 2'd0;
    checks++;
    if ({rst_out_n, seq_done, busy, rst_cause} !== want) begin
      errors++;
      $display("FAIL async_reset: got rst_out_n=%b seq_done=%b busy=%b rst_cause=%0d, want rst_out_n=%b seq_done=%b busy=%b rst_cause=%0d",
               rst_out_n, seq_done, busy, rst_cause, want.rst, want.done, want.bsy, want.cause);
    end
    @(posedge clock);
    model_edge();
  endtask

  // Monitor: the DUT presents a new output word after every rising edge.
  initial begin : monitor
    exp_t x;
    int   ed;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        x  = exp_q.pop_front();
        ed = edge_q.pop_front();
        checks++;
        if ({rst_out_n, seq_done, busy, rst_cause} !== x) begin
          errors++;
          $display("FAIL outputs edge %0d: got rst_out_n=%b seq_done=%b busy=%b rst_cause=%0d, want rst_out_n=%b seq_done=%b busy=%b rst_cause=%0d",
                   ed, rst_out_n, seq_done, busy, rst_cause, x.rst, x.done, x.bsy, x.cause);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: bench did not reach its end, checks=%0d", checks);
    $fatal(1);
  end

  initial begin : stimulus
    int   ext_left;
    int   rst_left;
    logic sw;
    logic ext;
    logic rn;

    // Power-on release.
    repeat (3) drive(1'b0, 1'b1, 1'b0);
    repeat (18) drive(1'b0, 1'b1, 1'b1);

    // One-cycle software reset while running.
    drive(1'b1, 1'b1, 1'b1);
    repeat (18) drive(1'b0, 1'b1, 1'b1);

    // Software reset, wait until domain 0 is out, then a 10-cycle external low.
    drive(1'b1, 1'b1, 1'b1);
    repeat (8) drive(1'b0, 1'b1, 1'b1);
    repeat (10) drive(1'b0, 1'b0, 1'b1);
    repeat (20) drive(1'b0, 1'b1, 1'b1);

    // External low reaching the FSM on the same edge as a software request.
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b1);
    repeat (20) drive(1'b0, 1'b1, 1'b1);

    // Software request held high: domain 0 must never come out.
    repeat (25) drive(1'b1, 1'b1, 1'b1);
    repeat (20) drive(1'b0, 1'b1, 1'b1);

    // Asynchronous rst_n mid-sequence, then a full power-on release.
    drive(1'b1, 1'b1, 1'b1);
    repeat (8) drive(1'b0, 1'b1, 1'b1);
    async_reset();
    drive(1'b0, 1'b1, 1'b0);
    repeat (20) drive(1'b0, 1'b1, 1'b1);

    // Randomized phase.
    ext_left = 0;
    rst_left = 0;
    repeat (400) begin
      sw = ($urandom_range(0, 14) == 0);
      if (ext_left == 0 && $urandom_range(0, 39) == 0) ext_left = $urandom_range(1, 8);
      ext = (ext_left == 0);
      if (ext_left > 0) ext_left--;
      if (rst_left == 0 && $urandom_range(0, 149) == 0) rst_left = $urandom_range(1, 3);
      rn = (rst_left == 0);
      if (rst_left > 0) rst_left--;
      drive(sw, ext, rn);
    end
    repeat (20) drive(1'b0, 1'b1, 1'b1);

    // Let the monitor consume the final expectation.
    @(negedge clock);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_reset_sequencer
`default_nettype wire
